// File: rtl/psram_pkg.sv
// ---------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the PSRAM Wishbone arbiter slice:
//   - state_t      : arbiter FSM state encodings
//   - GRANT_*      : one-hot grant encodings driven on grant_o
//   - DEF_*        : default fairness cap and watchdog timeout
//   - WDOG_W       : width of the watchdog counter
// ---------------------------------------------------------------------------
package psram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int DEF_MAX_BEATS = 16;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int WDOG_W        = 16;

endpackage

// File: rtl/psram_wb_watchdog.sv
// ---------------------------------------------------------------------------
// psram_wb_watchdog
// Generic stall watchdog: counts cycles while enabled, restarts from zero
// when cleared, and flags expiry on the cycle the count reaches the loaded
// limit while still enabled.
// Ports:
//   clk       in   clock
//   rst_n     in   synchronous active-low reset
//   i_en      in   count this cycle (stall condition present)
//   i_clr     in   restart the count from zero
//   i_limit   in   terminal count value (expiry when count == limit)
//   o_expire  out  limit reached on an enabled cycle
// ---------------------------------------------------------------------------
module psram_wb_watchdog
    import psram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [WDOG_W-1:0] i_limit,
    output logic              o_expire
);

    logic [WDOG_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + WDOG_W'(1);
        end
    end

    // Expiry is qualified by i_en so a cycle that clears (e.g. an ack
    // arriving on the terminal count) never reports a timeout.
    assign o_expire = i_en & (r_cnt == i_limit);

endmodule

// File: rtl/psram_wb_arbiter.sv
// ---------------------------------------------------------------------------
// psram_wb_arbiter
// Two-master Wishbone arbiter sharing one PSRAM slave between master 0
// (CPU data) and master 1 (DMA/video). Registered round-robin grant, a cap
// on consecutive beats while the other master waits, and a per-beat
// watchdog that returns err and frees the bus if the slave never acks.
// Ports:
//   sys_clk, sys_rst_n          clock, synchronous active-low reset
//   mN_adr_i/dat_i/sel_i        master N address, write data, byte selects
//   mN_cyc_i/stb_i/we_i         master N Wishbone controls
//   mN_dat_o                    read data (both driven from s_dat_i)
//   mN_ack_o/err_o              master N responses
//   s_adr_o/dat_o/sel_o         to PSRAM slave
//   s_cyc_o/stb_o/we_o          controls to PSRAM slave
//   s_dat_i, s_ack_i            PSRAM read data and ack
//   grant_o                     one-hot current owner, 00 when none
//   abort_o                     one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module psram_wb_arbiter
    import psram_pkg::*;
#(
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m0_dat_o,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m0_stb_i,
    input  logic        m1_stb_i,
    input  logic        m0_cyc_i,
    input  logic        m1_cyc_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic        m0_err_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic        s_we_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        abort_o
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W-1:0] BEAT_CAP = BEAT_W'(MAX_BEATS);
    localparam logic [WDOG_W-1:0] WD_LIMIT = WDOG_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_owner;
    logic              w_last_owner_nxt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic [BEAT_W-1:0] w_beat_inc;
    logic              w_beat_cap;
    logic              w_wd_en;
    logic              w_expire;

    // Saturating beat count: once the cap is reached with no competitor,
    // the owner keeps the bus and the next ack after the competitor shows
    // up hands the grant over.
    assign w_beat_inc = (r_beat_cnt == BEAT_CAP) ? r_beat_cnt : r_beat_cnt + BEAT_W'(1);
    assign w_beat_cap = (w_beat_inc == BEAT_CAP);

    // s_stb_o depends only on state and master inputs, so the watchdog
    // enable is the only place s_ack_i meets the strobe.
    assign w_wd_en = s_stb_o & ~s_ack_i;

    psram_wb_watchdog u_wdog (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .i_en     (w_wd_en),
        .i_clr    (~w_wd_en),
        .i_limit  (WD_LIMIT),
        .o_expire (w_expire)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat_cnt   <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_beat_nxt       = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                w_beat_nxt = '0;
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = 1'b0;
                end else if (w_expire) begin
                    w_state_nxt      = ST_ABORT;
                    w_last_owner_nxt = 1'b0;
                end else if (s_ack_i) begin
                    if (w_beat_cap && m1_cyc_i) begin
                        w_state_nxt      = ST_OWN1;
                        w_last_owner_nxt = 1'b0;
                        w_beat_nxt       = '0;
                    end else begin
                        w_beat_nxt = w_beat_inc;
                    end
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt      = ST_ABORT;
                    w_last_owner_nxt = 1'b1;
                end else if (s_ack_i) begin
                    if (w_beat_cap && m0_cyc_i) begin
                        w_state_nxt      = ST_OWN0;
                        w_last_owner_nxt = 1'b1;
                        w_beat_nxt       = '0;
                    end else begin
                        w_beat_nxt = w_beat_inc;
                    end
                end
            end
            ST_ABORT: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus mux: slave-side signals are all zero unless a master owns the bus,
    // so late acks in IDLE/ABORT are never routed.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        abort_o  = 1'b0;
        grant_o  = GRANT_NONE;
        case (r_state)
            ST_OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_cyc_i & m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_err_o = w_expire;
                abort_o  = w_expire;
                grant_o  = GRANT_M0;
            end
            ST_OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_cyc_i & m1_stb_i;
                m1_ack_o = s_ack_i;
                m1_err_o = w_expire;
                abort_o  = w_expire;
                grant_o  = GRANT_M1;
            end
            default: begin
            end
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_psram_wb_arbiter.sv
module tb_psram_wb_arbiter;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i, m0_we_i, m1_we_i;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_stb_o, s_cyc_o, s_we_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;
    logic        abort_o;

    int total = 0;
    int bad   = 0;

    psram_wb_arbiter #(.MAX_BEATS(16), .TIMEOUT(1024)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .m0_adr_i  (m0_adr_i),
        .m1_adr_i  (m1_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m1_dat_i  (m1_dat_i),
        .m0_dat_o  (m0_dat_o),
        .m1_dat_o  (m1_dat_o),
        .m0_sel_i  (m0_sel_i),
        .m1_sel_i  (m1_sel_i),
        .m0_stb_i  (m0_stb_i),
        .m1_stb_i  (m1_stb_i),
        .m0_cyc_i  (m0_cyc_i),
        .m1_cyc_i  (m1_cyc_i),
        .m0_we_i   (m0_we_i),
        .m1_we_i   (m1_we_i),
        .m0_ack_o  (m0_ack_o),
        .m1_ack_o  (m1_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_err_o  (m1_err_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_stb_o   (s_stb_o),
        .s_cyc_o   (s_cyc_o),
        .s_we_o    (s_we_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .grant_o   (grant_o),
        .abort_o   (abort_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sys_clk);
    endtask

    task automatic clear_inputs();
        m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
        m0_sel_i = 4'hF; m1_sel_i = 4'hF;
        m0_stb_i = 0; m1_stb_i = 0; m0_cyc_i = 0; m1_cyc_i = 0;
        m0_we_i = 0; m1_we_i = 0;
        s_dat_i = '0; s_ack_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        sys_rst_n = 0;
        step();
        step();
        sys_rst_n = 1;
    endtask

    initial begin
        int n0, n1, n0_at_switch, both, early;

        // ---- reset state ----
        clear_inputs();
        sys_rst_n = 0;
        step();
        step();
        sample();
        check("rst_grant", grant_o, 2'b00);
        check("rst_cyc", s_cyc_o, 0);
        check("rst_stb", s_stb_o, 0);
        check("rst_resp", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, abort_o}, 0);
        step();
        sys_rst_n = 1;

        // ---- single m0 read ----
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0100;
        sample();
        check("t1_c0_stb", s_stb_o, 0);
        step();
        sample();
        check("t1_c1_stb", s_stb_o, 1);
        check("t1_c1_grant", grant_o, 2'b01);
        check("t1_c1_adr", s_adr_o, 32'h0000_0100);
        step();
        step();
        step();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        sample();
        check("t1_c4_ack0", m0_ack_o, 1);
        check("t1_c4_dat0", m0_dat_o, 32'hDEAD_BEEF);
        check("t1_c4_ack1", m1_ack_o, 0);
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        sample();
        check("t1_c5_grant", grant_o, 2'b01);
        check("t1_c5_cyc", s_cyc_o, 0);
        step();
        sample();
        check("t1_c6_grant", grant_o, 2'b00);

        // ---- tie after reset, then round-robin tie ----
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        s_ack_i = 1;
        sample();
        check("t2_tie1_grant", grant_o, 2'b01);
        check("t2_tie1_ack0", m0_ack_o, 1);
        check("t2_tie1_ack1", m1_ack_o, 0);
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        sample();
        check("t2_bubble_grant", grant_o, 2'b00);
        step();
        s_ack_i = 1;
        sample();
        check("t2_tie2_grant", grant_o, 2'b10);
        check("t2_tie2_ack1", m1_ack_o, 1);
        check("t2_tie2_ack0", m0_ack_o, 0);
        step();
        s_ack_i = 0;
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        step();

        // ---- fairness cap: m0 wants 40 beats, m1 wants 5 ----
        n0 = 0; n1 = 0; n0_at_switch = -1; both = 0;
        for (int c = 0; c < 200 && !(n0 == 40 && n1 == 5); c++) begin
            m0_cyc_i = (n0 < 40); m0_stb_i = (n0 < 40);
            m1_cyc_i = (n1 < 5);  m1_stb_i = (n1 < 5);
            #1 s_ack_i = s_stb_o;
            sample();
            if (m0_ack_o && m1_ack_o) both++;
            if (m0_ack_o) n0++;
            if (m1_ack_o) begin
                if (n0_at_switch < 0) n0_at_switch = n0;
                n1++;
            end
            step();
        end
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        check("t3_m0_before_switch", n0_at_switch, 16);
        check("t3_m0_total", n0, 40);
        check("t3_m1_total", n1, 5);
        check("t3_dual_ack", both, 0);
        step();
        step();

        // ---- watchdog timeout, then pending m1 ----
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        m1_cyc_i = 1; m1_stb_i = 1;
        early = 0;
        for (int c = 1; c < 1024; c++) begin
            sample();
            if (m0_err_o || abort_o) early++;
            step();
        end
        sample();
        check("t4_early_err", early, 0);
        check("t4_err0", m0_err_o, 1);
        check("t4_abort", abort_o, 1);
        check("t4_err1", m1_err_o, 0);
        step();
        m0_cyc_i = 0; m0_stb_i = 0;
        sample();
        check("t4_abort_cyc", s_cyc_o, 0);
        check("t4_abort_grant", grant_o, 2'b00);
        check("t4_abort_pulse", abort_o, 0);
        step();
        sample();
        check("t4_idle_grant", grant_o, 2'b00);
        step();
        s_ack_i = 1;
        sample();
        check("t4_m1_grant", grant_o, 2'b10);
        check("t4_m1_cyc", s_cyc_o, 1);
        check("t4_m1_ack", m1_ack_o, 1);
        step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        step();

        // ---- ack on the exact timeout cycle ----
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        for (int c = 1; c < 1024; c++) step();
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        sample();
        check("t5_ack", m0_ack_o, 1);
        check("t5_dat", m0_dat_o, 32'h1234_5678);
        check("t5_no_err", m0_err_o, 0);
        check("t5_no_abort", abort_o, 0);
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        sample();
        check("t5_still_own", grant_o, 2'b01);
        step();
        sample();
        check("t5_idle", grant_o, 2'b00);

        // ---- reset during an m1 write beat ----
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
        m1_adr_i = 32'h0000_0200; m1_dat_i = 32'hCAFE_F00D;
        step();
        sample();
        check("t6_grant", grant_o, 2'b10);
        check("t6_we", s_we_o, 1);
        check("t6_wdat", s_dat_o, 32'hCAFE_F00D);
        sys_rst_n = 0;
        step();
        sys_rst_n = 1;
        sample();
        check("t6_rst_cyc", s_cyc_o, 0);
        check("t6_rst_stb", s_stb_o, 0);
        check("t6_rst_we", s_we_o, 0);
        check("t6_rst_adr", s_adr_o, 32'h0);
        check("t6_rst_grant", grant_o, 2'b00);
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        step();
        step();
        s_ack_i = 1;
        sample();
        check("t6_stray_ack", {m0_ack_o, m1_ack_o}, 2'b00);
        step();
        s_ack_i = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
